result_drain: RTL and testbench
===============================

# result_drain

Output drain stage downstream of the 2x2 systolic array. It captures a completed tile of four 16-bit accumulations (c00, c01, c10, c11) into a two-slot ping-pong buffer. It then streams each tile out byte by byte over a valid/ready handshake, so the array can start the next tile while the previous one is still draining to the 8-bit pad interface.

## Interface
- HI_FIRST, default 1: byte order within each 16-bit element. 1 = [15:8] then [7:0]; 0 = [7:0] then [15:8]. Ignored when RESULT_DRAIN_SAT8_EN is defined.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cap_valid  in  1  high for one or more cycles while c00..c11 hold a finished tile.
- cap_ready  out  1  at least one buffer slot is free.
- c00, c01, c10, c11  in  16 each  signed two's-complement accumulations from the array.
- out_data  out  8  current output byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_last  out  1  out_data is the final byte of the current tile; qualified by out_valid.
- overflow  out  1  sticky; set when cap_valid is high while cap_ready is low.
- tiles_done  out  8  count of fully drained tiles; wraps modulo 256.

## Operation
- Storage: two slots of 4x16 bits, plus write pointer wp, read pointer rp, occupancy cnt (0..2) and byte index idx.
- Reset values: wp=0, rp=0, cnt=0, idx=0, overflow=0, tiles_done=0. Outputs after reset: cap_ready=1, out_valid=0, out_last=0, out_data=0x00.
- cap_ready = (cnt != 2). It is a function of registered state only and never depends on out_ready.
- Capture: when cap_valid && cap_ready, the slot at wp stores {c00,c01,c10,c11}, wp toggles and cnt increments. A cap_valid held for N cycles captures N times; upstream is responsible for pulsing it.
- Capture while full: when cap_valid && !cap_ready, data is dropped and overflow is set. overflow is cleared only by rst.
- out_valid = (cnt != 0). out_data selects byte idx of the slot at rp.
  - Stream order is c00, c01, c10, c11.
  - Each element is emitted per HI_FIRST, giving 8 bytes per tile (idx 0..7).
  - out_data = 0x00 when cnt == 0.
- Pop: when out_valid && out_ready, idx increments.
  - On the last byte (idx == 7, or 3 in SAT8 mode), idx returns to 0, rp toggles, cnt decrements and tiles_done increments.
  - out_last is high exactly when out_valid is high and idx is at the last byte.
- Occupancy cases:
  - Capture and final-byte pop in the same cycle with cnt == 1: cnt stays 1 and both pointers toggle.
  - cnt == 2: capture is blocked, so a pop takes cnt to 1.
  - cnt == 0: no pop is possible.
- Effective state machine on cnt: EMPTY(0) → ONE(1) on capture. ONE → FULL(2) on capture without final pop. ONE → EMPTY on final pop without capture. FULL → ONE on final pop.
- Handshake rule: once out_valid is high, out_data and out_last stay stable until accepted. out_valid never drops without a pop, except on rst.
- rst mid-stream: both slots are discarded and idx=0. out_valid is 0 in the cycle after the reset edge.

## Timing
- Capture to first byte: the tile captured at edge k has out_valid=1 and its first byte on out_data after edge k when the buffer was empty. Latency is 1 cycle.
- Throughput with out_ready held high: one byte per cycle, 8 cycles per tile (4 in SAT8 mode).
- Back-to-back tiles with no bubble: the last byte of slot A is followed by the first byte of slot B on the next cycle.
- cap_ready rises in the cycle after the final-byte pop edge of a full buffer.
- out_data, out_valid and out_last are combinational from registers only. There is no input-to-output combinational path.

## Configuration
- RESULT_DRAIN_SAT8_EN defined:
  - Each element is saturated to signed 8 bits at capture: values > 127 become 0x7F, values < -128 become 0x80, otherwise bits [7:0] pass through.
  - Slots store 4x8 bits, 4 bytes per tile, idx 0..3. HI_FIRST is ignored.
- RESULT_DRAIN_SAT8_EN undefined: full 16-bit elements, 8 bytes per tile as described above.

## Test plan
- Reset then one capture of c00=0x0102, c01=0x0304, c10=0x0506, c11=0x0708, out_ready=1, HI_FIRST=1 -> bytes 01,02,03,04,05,06,07,08 on consecutive cycles. out_last is high on 08 only. tiles_done=1, then out_valid=0.
- Two captures with out_ready=0 -> cap_ready=0 after the second. A third cap_valid sets overflow=1, and the first tile's data is unchanged when later drained.
- Backpressure: out_ready toggling 1,0,1,0 -> out_data holds each byte while out_ready=0. Order and count match the first scenario.
- Ping-pong: capture tile A, and capture tile B on the cycle A's last byte is popped (cnt=1) -> A's 8 bytes then B's 8 bytes with no gap. tiles_done=2.
- rst asserted after 3 bytes of a tile -> next cycle out_valid=0, cap_ready=1, overflow=0, tiles_done=0.
- SAT8 build: c00=0x0200, c01=0xFE00, c10=0x0045, c11=0xFFF0 -> bytes 7F,80,45,F0 with out_last on F0.

Source files
------------

// File: rtl/result_drain.sv
// result_drain
//
// Output drain stage behind the 2x2 systolic array. A finished tile of four
// signed 16-bit accumulations (c00, c01, c10, c11) is captured into one of two
// ping-pong slots. Tiles are then streamed out one byte at a time to an 8-bit
// pad interface, so the array can start the next tile while the previous one
// is still draining.
//
// Parameters
//   HI_FIRST   1: each element goes out as [15:8] then [7:0]; 0: [7:0] then [15:8].
//              Ignored when RESULT_DRAIN_SAT8_EN is defined.
//
// Build option
//   RESULT_DRAIN_SAT8_EN  when defined, every element is saturated to signed
//                         8 bits at capture. A tile is then 4 bytes instead of 8.
//
// Ports
//   clk, rst         single clock; synchronous active-high reset
//   cap_valid        tile on c00..c11 is complete (captures once per cycle held)
//   cap_ready        at least one slot is free (registered state only)
//   c00..c11         signed 16-bit accumulations
//   out_data         current output byte (0x00 when nothing is buffered)
//   out_valid        out_data is valid
//   out_ready        consumer takes out_data this cycle
//   out_last         out_data is the final byte of the current tile
//   overflow         sticky; a capture was attempted while both slots were full
//   tiles_done       number of fully drained tiles, modulo 256
//   dbg_state        occupancy state (0 empty, 1 one slot, 2 full)
//
// Handshake: a byte transfers on a rising edge where out_valid && out_ready.
// Once out_valid is high, out_data and out_last hold until that transfer. Only
// rst can drop out_valid without a transfer. A capture takes place on a rising
// edge where cap_valid && cap_ready. cap_ready never depends on out_ready.
// Every output is driven from registers only.
module result_drain #(
    parameter bit HI_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_valid,
    output logic        cap_ready,
    input  logic [15:0] c00,
    input  logic [15:0] c01,
    input  logic [15:0] c10,
    input  logic [15:0] c11,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        overflow,
    output logic [7:0]  tiles_done,
    output logic [1:0]  dbg_state
);

`ifdef RESULT_DRAIN_SAT8_EN
    localparam int EW   = 8;
    localparam int IDXW = 2;
`else
    localparam int EW   = 16;
    localparam int IDXW = 3;
`endif
    localparam logic [IDXW-1:0] IDX_LAST = '1;

    // The state value is the number of occupied slots.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              wp_q, wp_d;
    logic              rp_q, rp_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        tiles_done_q, tiles_done_d;
    logic [EW-1:0]     mem_q [2][4];
    logic [EW-1:0]     mem_d [2][4];

    logic              cap_fire;
    logic              pop;
    logic              final_pop;
    logic              at_last;
    logic [EW-1:0]     cur_elem;
    logic [EW-1:0]     cap_elem [4];

`ifdef RESULT_DRAIN_SAT8_EN
    // Clamp a signed 16-bit value to the signed 8-bit range.
    function automatic logic [7:0] sat8(input logic [15:0] v);
        logic [7:0] r;
        if ($signed(v) > 16'sd127) begin
            r = 8'h7F;
        end else if ($signed(v) < -16'sd128) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    always_comb begin
        cap_elem[0] = sat8(c00);
        cap_elem[1] = sat8(c01);
        cap_elem[2] = sat8(c10);
        cap_elem[3] = sat8(c11);
    end
`else
    always_comb begin
        cap_elem[0] = c00;
        cap_elem[1] = c01;
        cap_elem[2] = c10;
        cap_elem[3] = c11;
    end
`endif

    // Handshake qualifiers
    always_comb begin
        cap_ready = (state_q != ST_FULL);
        out_valid = (state_q != ST_EMPTY);
        at_last   = (idx_q == IDX_LAST);
        cap_fire  = cap_valid && cap_ready;
        pop       = out_valid && out_ready;
        final_pop = pop && at_last;
    end

    // Occupancy state machine and pointer, index and counter updates
    always_comb begin
        state_d      = state_q;
        wp_d         = wp_q;
        rp_d         = rp_q;
        idx_d        = idx_q;
        overflow_d   = overflow_q;
        tiles_done_d = tiles_done_q;
        mem_d        = mem_q;

        if (cap_fire) begin
            for (int e = 0; e < 4; e++) begin
                mem_d[wp_q][e] = cap_elem[e];
            end
            wp_d = ~wp_q;
        end

        if (cap_valid && !cap_ready) begin
            overflow_d = 1'b1;
        end

        if (pop) begin
            if (at_last) begin
                idx_d        = '0;
                rp_d         = ~rp_q;
                tiles_done_d = tiles_done_q + 8'd1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        case (state_q)
            ST_EMPTY: begin
                if (cap_fire) state_d = ST_ONE;
            end
            ST_ONE: begin
                // A capture and a final pop in the same cycle leave one slot occupied.
                if (cap_fire && !final_pop) begin
                    state_d = ST_FULL;
                end else if (final_pop && !cap_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (final_pop) state_d = ST_ONE;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Output byte selection from the slot at the read pointer
    always_comb begin
        out_data = 8'h00;
`ifdef RESULT_DRAIN_SAT8_EN
        cur_elem = mem_q[rp_q][idx_q];
        if (out_valid) out_data = cur_elem;
`else
        cur_elem = mem_q[rp_q][idx_q[2:1]];
        // Even byte index is the first byte of the element.
        if (out_valid) begin
            if ((idx_q[0] == 1'b0) == HI_FIRST) begin
                out_data = cur_elem[15:8];
            end else begin
                out_data = cur_elem[7:0];
            end
        end
`endif
        out_last   = out_valid && at_last;
        overflow   = overflow_q;
        tiles_done = tiles_done_q;
        dbg_state  = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            wp_q         <= 1'b0;
            rp_q         <= 1'b0;
            idx_q        <= '0;
            overflow_q   <= 1'b0;
            tiles_done_q <= 8'd0;
            for (int s = 0; s < 2; s++) begin
                for (int e = 0; e < 4; e++) begin
                    mem_q[s][e] <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            idx_q        <= idx_d;
            overflow_q   <= overflow_d;
            tiles_done_q <= tiles_done_d;
            mem_q        <= mem_d;
        end
    end

endmodule

// File: tb/tb_result_drain.sv
// Testbench for result_drain. The stimulus tasks drive inputs shortly after
// each rising edge. The monitor samples on the falling edge. It compares the
// DUT against a tile-level reference model: a queue of expected bytes plus a
// count of buffered tiles. It then advances the model by what the next rising
// edge will do.
module tb_result_drain;

    localparam bit TB_HI_FIRST = 1'b1;

    logic        clk;
    logic        rst;
    logic        cap_valid;
    logic        cap_ready;
    logic [15:0] c00, c01, c10, c11;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        overflow;
    logic [7:0]  tiles_done;
    logic [1:0]  dbg_state;

    result_drain #(.HI_FIRST(TB_HI_FIRST)) dut (
        .clk        (clk),
        .rst        (rst),
        .cap_valid  (cap_valid),
        .cap_ready  (cap_ready),
        .c00        (c00),
        .c01        (c01),
        .c10        (c10),
        .c11        (c11),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .overflow   (overflow),
        .tiles_done (tiles_done),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [8:0] exp_q[$];    // {last, byte}
    int         model_tiles;
    logic       model_ovf;
    logic [7:0] model_done;
    bit         started;
    int         n_checks;
    int         n_fail;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] sat_byte(input logic [15:0] e);
        int v;
        v = $signed(e);
        if (v > 127) return 8'h7F;
        if (v < -128) return 8'h80;
        return v[7:0];
    endfunction

    // Expected bytes of one tile, in stream order c00, c01, c10, c11
    task automatic push_tile(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d);
        logic [15:0] el[4];
        logic [7:0]  bytes[$];
        el[0] = a; el[1] = b; el[2] = c; el[3] = d;
        for (int i = 0; i < 4; i++) begin
`ifdef RESULT_DRAIN_SAT8_EN
            bytes.push_back(sat_byte(el[i]));
`else
            if (TB_HI_FIRST) begin
                bytes.push_back(el[i][15:8]);
                bytes.push_back(el[i][7:0]);
            end else begin
                bytes.push_back(el[i][7:0]);
                bytes.push_back(el[i][15:8]);
            end
`endif
        end
        for (int i = 0; i < bytes.size(); i++) begin
            exp_q.push_back({(i == bytes.size() - 1), bytes[i]});
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [8:0] front;
        bit         cap_ok;
        if (started) begin
            check("cap_ready", {15'd0, cap_ready}, {15'd0, (model_tiles != 2)});
            check("out_valid", {15'd0, out_valid}, {15'd0, (model_tiles != 0)});
            check("overflow", {15'd0, overflow}, {15'd0, model_ovf});
            check("tiles_done", {8'd0, tiles_done}, {8'd0, model_done});
            if (model_tiles != 0 && exp_q.size() != 0) begin
                front = exp_q[0];
                check("out_data", {8'd0, out_data}, {8'd0, front[7:0]});
                check("out_last", {15'd0, out_last}, {15'd0, front[8]});
            end else begin
                check("out_data_idle", {8'd0, out_data}, 16'h0000);
                check("out_last_idle", {15'd0, out_last}, 16'h0000);
            end
        end
        if (rst) begin
            exp_q.delete();
            model_tiles = 0;
            model_ovf   = 1'b0;
            model_done  = 8'd0;
            started     = 1'b1;
        end else if (started) begin
            cap_ok = (model_tiles != 2);
            if (out_ready && model_tiles != 0 && exp_q.size() != 0) begin
                front = exp_q.pop_front();
                if (front[8]) begin
                    model_tiles--;
                    model_done++;
                end
            end
            if (cap_valid) begin
                if (cap_ok) begin
                    push_tile(c00, c01, c10, c11);
                    model_tiles++;
                end else begin
                    model_ovf = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic cv, input logic ordy,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        cap_valid = cv;
        out_ready = ordy;
        c00 = a; c01 = b; c10 = c; c11 = d;
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, ordy, 16'h0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        cap_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks    = 0;
        n_fail      = 0;
        started     = 1'b0;
        model_tiles = 0;
        model_ovf   = 1'b0;
        model_done  = 8'd0;
        rst         = 1'b1;
        cap_valid   = 1'b0;
        out_ready   = 1'b0;
        c00 = 16'h0; c01 = 16'h0; c10 = 16'h0; c11 = 16'h0;
        repeat (2) @(posedge clk);

        // Single tile, free-running consumer
        drive(1'b1, 1'b1, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
        idle(1'b1, 10);

        // Two captures with the consumer stalled, a third overflows
        drive(1'b1, 1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        drive(1'b1, 1'b0, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
        drive(1'b1, 1'b0, 16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D);
        idle(1'b0, 2);
        idle(1'b1, 18);

        // Backpressure: ready alternates
        drive(1'b1, 1'b1, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
        for (int i = 0; i < 20; i++) drive(1'b0, (i % 2 == 1), 16'h0, 16'h0, 16'h0, 16'h0);
        idle(1'b1, 4);

        // Ping-pong: B captured on the edge that pops A's last byte
        drive(1'b1, 1'b1, 16'hA0A1, 16'hA2A3, 16'hA4A5, 16'hA6A7);
        idle(1'b1, 7);
        drive(1'b1, 1'b1, 16'hB0B1, 16'hB2B3, 16'hB4B5, 16'hB6B7);
        idle(1'b1, 10);

        // Saturation corner values
        drive(1'b1, 1'b1, 16'h0200, 16'hFE00, 16'h0045, 16'hFFF0);
        drive(1'b1, 1'b1, 16'h007F, 16'hFF80, 16'h0080, 16'hFF7F);
        idle(1'b1, 18);

        // Overflow set, then reset mid-stream after 3 bytes
        drive(1'b1, 1'b0, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        drive(1'b1, 1'b0, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        drive(1'b1, 1'b1, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        idle(1'b1, 2);
        do_reset();
        idle(1'b1, 3);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                drive(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7),
                      16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            end
        end
        idle(1'b1, 24);

        @(posedge clk);
        #1;
        check("drain_empty", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
